// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Front end for the clock's push buttons (mode, set, op1, op2). Each raw
// button level is synchronised, debounced, and turned into a one-cycle press
// strobe. Buttons enabled in REPEAT_MASK also emit auto-repeat strobes while
// held: the first after REPEAT_DELAY cycles, then one every REPEAT_PERIOD.
//
// Ports
//   clk        in   1        system clock, all logic on rising edge
//   reset      in   1        synchronous, active-high; clears all state
//   btn_in     in   NUM_BTN  raw asynchronous button levels, 1 = pressed
//   btn_level  out  NUM_BTN  debounced level, registered
//   btn_pulse  out  NUM_BTN  one-cycle press/repeat strobe, registered
//
// Bit order: bit0 = mode, bit1 = set, bit2 = op1, bit3 = op2.
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int                 NUM_BTN         = 4,
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter int                 REPEAT_DELAY    = 25000000,
    parameter int                 REPEAT_PERIOD   = 5000000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b1100,
    parameter int                 CNT_W           = 25
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [NUM_BTN-1:0] sync_p0;
    logic [NUM_BTN-1:0] sync_p1;
    logic [CNT_W-1:0]   dcnt  [NUM_BTN];
    logic [CNT_W-1:0]   rcnt  [NUM_BTN];
    state_t             state [NUM_BTN];

    // Value btn_level takes on this edge. The FSMs key off it so the press
    // strobe lands on the same edge the debounced level rises, and a release
    // takes priority over a repeat terminal count on that edge.
    logic [NUM_BTN-1:0] level_nxt;

    always_comb begin
        level_nxt = btn_level;
        for (int i = 0; i < NUM_BTN; i++) begin
            if ((sync_p1[i] != btn_level[i]) && (dcnt[i] == DEB_LAST)) begin
                level_nxt[i] = sync_p1[i];
            end
        end
    end

    // ---- stage p0/p1: two-flop synchroniser ----
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage p2: debounce ----
    // A sample that agrees with the current level restarts the count, so only
    // DEBOUNCE_CYCLES consecutive disagreeing samples flip the level.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            btn_level <= level_nxt;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync_p1[i] == btn_level[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_LAST) begin
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CNT_ONE;
                end
            end
        end
    end

    // ---- stage p3: press / auto-repeat FSMs ----
    // Repeat counters clear at their terminal count, so they never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_pulse <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                state[i] <= IDLE;
                rcnt[i]  <= '0;
            end
        end else begin
            btn_pulse <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                case (state[i])
                    IDLE: begin
                        if (level_nxt[i] && !btn_level[i]) begin
                            btn_pulse[i] <= 1'b1;
                            rcnt[i]      <= '0;
                            state[i]     <= HELD;
                        end
                    end
                    HELD: begin
                        if (!level_nxt[i]) begin
                            rcnt[i]  <= '0;
                            state[i] <= IDLE;
                        end else if (!REPEAT_MASK[i]) begin
                            rcnt[i] <= '0;
                        end else if (rcnt[i] == DLY_LAST) begin
                            btn_pulse[i] <= 1'b1;
                            rcnt[i]      <= '0;
                            state[i]     <= REPEAT;
                        end else begin
                            rcnt[i] <= rcnt[i] + CNT_ONE;
                        end
                    end
                    REPEAT: begin
                        if (!level_nxt[i]) begin
                            rcnt[i]  <= '0;
                            state[i] <= IDLE;
                        end else if (rcnt[i] == PER_LAST) begin
                            btn_pulse[i] <= 1'b1;
                            rcnt[i]      <= '0;
                        end else begin
                            rcnt[i] <= rcnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        rcnt[i]  <= '0;
                        state[i] <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
